// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_state_e;

    localparam int   UART_DATA_BITS   = 7;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_PARITY_EVEN = 1'b1;

    // Parity bit that makes data plus parity satisfy the link's parity sense.
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data);
        return (^data) ^ ~UART_PARITY_EVEN;
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receive-side result bundle: the received word, its status flags and the strobe.
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 7
);
    logic [DATA_BITS-1:0] data_out;
    logic                 parity;
    logic                 parity_err;
    logic                 frame_err;
    logic                 is_received;
    logic                 busy;

    modport master (
        output data_out, parity, parity_err, frame_err, is_received, busy
    );

    modport slave (
        input data_out, parity, parity_err, frame_err, is_received, busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; reset forces the
// idle level so the receiver never sees a false start edge out of reset.
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{UART_IDLE_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start(0), DATA_BITS data LSB first, even parity,
// stop(1). Samples mid-bit, rejects start glitches, flags parity/framing errors.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in_bit,
    uart_rx_oversampled_if.master rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rxs;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 parity_q, parity_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rcv_q, rcv_d;
    logic                 busy_q, busy_d;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in_bit),
        .q   (rxs)
    );

    // NOTE: every _d is given a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        data_d       = data_q;
        parity_d     = parity_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rcv_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // The cycle that detects the falling edge is the first count of the start bit.
                if (rxs != UART_IDLE_LEVEL) begin
                    state_d = ST_START;
                    cnt_d   = CNT_W'(1);
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rxs;
                    state_d   = ST_STOP;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    data_d       = shift_q;
                    parity_d     = par_bit_q;
                    parity_err_d = uart_parity(shift_q) ^ par_bit_q;
                    frame_err_d  = ~rxs;
                    rcv_d        = 1'b1;
                    // A low stop bit means break or stuck line: wait for idle before rearming.
                    state_d      = rxs ? ST_IDLE : ST_WAIT_HIGH;
                end
            end

            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs == UART_IDLE_LEVEL) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: the shift register is reset along with the outputs; it is a handful of flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            data_q       <= '0;
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rcv_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            data_q       <= data_d;
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rcv_q        <= rcv_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_if.data_out    = data_q;
    assign rx_if.parity      = parity_q;
    assign rx_if.parity_err  = parity_err_q;
    assign rx_if.frame_err   = frame_err_q;
    assign rx_if.is_received = rcv_q;
    assign rx_if.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench: ideal 16 clk/bit frames, a frame-level expectation queue
// for strobe timing and contents, plus literal checks of the directed cases.
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    localparam int CPB = 16;
    // Line falls 2 ns after edge n, so E0 = n+1 and the strobe is seen after edge E0+153 = n+154.
    localparam int LAT = 154;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in_bit = 1'b1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_oversampled_if #(.DATA_BITS(7)) rx_if ();

    uart_rx_oversampled #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in_bit (rx_in_bit),
        .rx_if     (rx_if)
    );

    typedef struct {
        logic [6:0] data;
        logic       par;
        logic       stop;
        int         when;
    } exp_t;

    typedef struct {
        logic [6:0] data;
        logic       par;
        logic       perr;
        logic       ferr;
        int         when;
    } obs_t;

    exp_t       exp_q[$];
    obs_t       seen[$];
    logic [6:0] m_data = '0;
    logic       m_par  = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison against the frame-level model.
    always @(negedge clk) begin
        logic exp_rcv;
        if (rst) begin
            exp_q.delete();
            m_data = '0;
            m_par  = 1'b0;
            m_perr = 1'b0;
            m_ferr = 1'b0;
            check("rst_data_out",    int'(rx_if.data_out),    0);
            check("rst_parity",      int'(rx_if.parity),      0);
            check("rst_parity_err",  int'(rx_if.parity_err),  0);
            check("rst_frame_err",   int'(rx_if.frame_err),   0);
            check("rst_is_received", int'(rx_if.is_received), 0);
            check("rst_busy",        int'(rx_if.busy),        0);
        end else begin
            exp_rcv = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].when <= cyc) begin
                exp_rcv = (exp_q[0].when == cyc);
                m_data  = exp_q[0].data;
                m_par   = exp_q[0].par;
                m_perr  = ^{exp_q[0].data, exp_q[0].par};
                m_ferr  = ~exp_q[0].stop;
                void'(exp_q.pop_front());
            end
            check("is_received", int'(rx_if.is_received), int'(exp_rcv));
            if (rx_if.is_received) begin
                seen.push_back('{rx_if.data_out, rx_if.parity, rx_if.parity_err,
                                 rx_if.frame_err, cyc});
            end
            check("data_out",   int'(rx_if.data_out),   int'(m_data));
            check("parity",     int'(rx_if.parity),     int'(m_par));
            check("parity_err", int'(rx_if.parity_err), int'(m_perr));
            check("frame_err",  int'(rx_if.frame_err),  int'(m_ferr));
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic drive_bits(input logic [6:0] d, input logic p, input logic s, input int nbits);
        logic [9:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in_bit = f[i];
            repeat (CPB) @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [6:0] d, input logic p, input logic s);
        exp_q.push_back('{d, p, s, cyc + LAT});
        drive_bits(d, p, s, 10);
    endtask

    task automatic check_seen(input string tag, input int idx, input logic [6:0] d,
                              input logic p, input logic perr, input logic ferr);
        if (idx < seen.size()) begin
            check({tag, "_data"}, int'(seen[idx].data), int'(d));
            check({tag, "_par"},  int'(seen[idx].par),  int'(p));
            check({tag, "_perr"}, int'(seen[idx].perr), int'(perr));
            check({tag, "_ferr"}, int'(seen[idx].ferr), int'(ferr));
        end else begin
            check({tag, "_present"}, seen.size(), idx + 1);
        end
    endtask

    logic [6:0] sent[$];

    initial begin
        int         t0;
        logic [6:0] d;
        logic       p;

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) align();

        // 1: single clean frame, strobe timing pinned.
        seen.delete();
        t0 = cyc;
        send(7'h55, 1'b0, 1'b1);
        repeat (4) align();
        check("t1_count", seen.size(), 1);
        check_seen("t1", 0, 7'h55, 1'b0, 1'b0, 1'b0);
        if (seen.size() > 0) check("t1_strobe_cycle", seen[0].when, t0 + 154);

        // 2: back-to-back frames, second with bad parity.
        seen.delete();
        send(7'h7F, 1'b1, 1'b1);
        send(7'h01, 1'b0, 1'b1);
        repeat (4) align();
        check("t2_count", seen.size(), 2);
        check_seen("t2a", 0, 7'h7F, 1'b1, 1'b0, 1'b0);
        check_seen("t2b", 1, 7'h01, 1'b0, 1'b1, 1'b0);

        // 3: start glitch of 4 cycles.
        seen.delete();
        t0 = cyc;
        rx_in_bit = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rx_in_bit = 1'b1;
        wait_neg(t0 + 4);
        check("t3_busy_high", int'(rx_if.busy), 1);
        wait_neg(t0 + 30);
        check("t3_busy_low", int'(rx_if.busy), 0);
        check("t3_no_strobe", seen.size(), 0);
        check("t3_data_held", int'(rx_if.data_out), 'h01);
        align();

        // 4: framing error with the line held low afterwards.
        seen.delete();
        send(7'h2A, 1'b1, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        rx_in_bit = 1'b1;
        t0 = cyc;
        wait_neg(t0 + 1);
        check("t4_busy_while_low", int'(rx_if.busy), 1);
        wait_neg(t0 + 4);
        check("t4_busy_released", int'(rx_if.busy), 0);
        align();
        repeat (20) align();
        check("t4_count", seen.size(), 1);
        check_seen("t4", 0, 7'h2A, 1'b1, 1'b0, 1'b1);

        // 5: reset during data bit 3 discards the partial frame.
        seen.delete();
        drive_bits(7'h5A, 1'b0, 1'b1, 4);
        rx_in_bit = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_data", int'(rx_if.data_out), 0);
        check("t5_rst_busy", int'(rx_if.busy), 0);
        align();
        repeat (2) align();
        rst = 1'b0;
        repeat (20) align();
        send(7'h13, uart_parity(7'h13), 1'b1);
        repeat (4) align();
        check("t5_count", seen.size(), 1);
        check_seen("t5", 0, 7'h13, 1'b1, 1'b0, 1'b0);

        // 6: loopback of random words from an ideal transmitter.
        seen.delete();
        sent.delete();
        for (int i = 0; i < 20; i++) begin
            d = 7'($urandom);
            sent.push_back(d);
            send(d, uart_parity(d), 1'b1);
            repeat ($urandom_range(0, 12)) align();
        end
        repeat (4) align();
        check("t6_count", seen.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < seen.size()) begin
                check("t6_data", int'(seen[i].data), int'(sent[i]));
                check("t6_perr", int'(seen[i].perr), 0);
                check("t6_ferr", int'(seen[i].ferr), 0);
            end
        end

        // 7: random words with random parity bits, back-to-back; model checks flags.
        seen.delete();
        for (int i = 0; i < 12; i++) begin
            d = 7'($urandom);
            p = 1'($urandom);
            send(d, p, 1'b1);
        end
        repeat (4) align();
        check("t7_count", seen.size(), 12);

        repeat (10) align();
        check("pending_strobes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
